order_bus_responder: RTL and testbench
======================================

// Module: order_bus_responder
// PURPOSE
//  Responder end of the instruction-fetch bus: receives add_bus from the fetch stage, returns data_bus plus isCplt.
//  Holds a small direct-mapped instruction buffer and fills misses from external memory over a req/ack handshake.
//  Sits between the fetch stage and the memory/bus bridge; fetch stalls while isCplt=0.
// PARAMETERS
//  LINES      16     buffer entries, power of 2 (>=2); IDX=log2(LINES)
//  TIMEOUT    255    max cycles waiting for mem_ack before a fault word is returned
//  FAULT_NUM  8'd17  soft-interrupt number returned on memory timeout
//  ALIGN_NUM  8'd18  soft-interrupt number returned on misaligned fetch
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-low reset
//  add_bus    in   32  fetch address; held stable by fetch while isCplt=0
//  data_bus   out  32  instruction word; 0 (nop) whenever isCplt=0
//  isCplt     out  1   1 = data_bus valid for add_bus this cycle
//  flush      in   1   1-cycle pulse: invalidate all entries
//  mem_req    out  1   registered request to memory
//  mem_addr   out  32  registered word address of request
//  mem_ack    in   1   1 = mem_rdata valid; completes request
//  mem_rdata  in   32  returned instruction word
// BEHAVIOUR
//  - Reset (async, rst=0): all valid bits 0, state IDLE, mem_req=0, mem_addr=0, timeout count 0; outputs data_bus=0, isCplt=0.
//  - Index=add_bus[IDX+1:2], tag=add_bus[31:IDX+2]. Fault word = {5'd13,19'd0,num} (soft-interrupt opcode).
//  - Misaligned (add_bus[1:0]!=0), any state: isCplt=1, data_bus={5'd13,19'd0,ALIGN_NUM} same cycle; no mem_req, nothing cached.
//  - IDLE: hit (valid & tag match) -> isCplt=1, data_bus=entry, combinational, 0-cycle latency.
//    Miss -> next edge: latch mem_addr={add_bus[31:2],2'b00}, mem_req<=1, count<=0, state WAIT.
//  - WAIT: mem_req held 1 until ack; count increments each cycle.
//    mem_ack=1: mem_req<=0, entry[index(mem_addr)] written {tag,mem_rdata} and valid set unless poisoned; state IDLE.
//      Same cycle, if add_bus==mem_addr: isCplt=1, data_bus=mem_rdata (bypass). Miss penalty = 1 + memory latency.
//      If add_bus differs (fetch redirected by rst/flush in the pipeline), fill still cached, no bypass; relookup in IDLE.
//    count==TIMEOUT and no ack: mem_req<=0, state IDLE, entry not written; that cycle isCplt=1, data_bus={5'd13,19'd0,FAULT_NUM}
//      if add_bus==mem_addr, else isCplt=0. A late mem_ack while IDLE is ignored.
//    ack and timeout in same cycle: ack wins.
//  - flush: clears all valid bits at next edge; if in WAIT (or flush coincides with ack), pending fill is poisoned:
//    data still bypassed to fetch, not cached. flush and write same cycle: flush wins.
//  - isCplt never 1 in WAIT except on the ack/timeout cycle; outside those cases data_bus=0.
//  - No new request issued while WAIT; only one outstanding request.
// STRUCTURE
//  - Shared package: state enum {IDLE,WAIT}, OPC_SOFTINT=5'd13, fault word builder constants, FAULT_NUM/ALIGN_NUM defaults.
//  - One sub-module: order_buf_array (LINES x {valid,tag,word}, 1 async read port, 1 write port, synchronous flush clear).
//  - Top holds FSM, timeout counter, poison flag, bypass/fault muxing.
// TESTING
//  1 Cold miss: rst release, add_bus=0x0000_0000, ack 3 cycles after req with 0x5800_0100 -> mem_req high cycle 1,
//    isCplt=1/data 0x5800_0100 on ack cycle; next cycle same address hits with 0-cycle latency, no mem_req.
//  2 Conflict (LINES=16): fetch 0x0, then 0x40, then 0x0 -> three misses; 0x40 evicts 0x0; 0x4 in between stays untouched.
//  3 Misaligned add_bus=0x0000_0002 -> isCplt=1, data_bus=0x6800_0012 same cycle, mem_req stays 0.
//  4 Timeout: add_bus=0x100, mem_ack never -> after TIMEOUT cycles isCplt=1, data_bus=0x6800_0011, mem_req=0;
//    refetch 0x100 misses again; late ack ignored.
//  5 flush pulse in WAIT, ack 0x1234_5678 -> delivered with isCplt=1, refetch of same address misses; flush while IDLE
//    after hits -> all next fetches miss.
//  6 rst=0 mid-WAIT -> mem_req=0, isCplt=0 immediately (async); after release previously cached address misses.

Source files
------------

// File: rtl/order_bus_responder_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package order_bus_responder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [4:0] OPC_SOFTINT   = 5'd13;
    localparam logic [7:0] FAULT_NUM_DEF = 8'd17;
    localparam logic [7:0] ALIGN_NUM_DEF = 8'd18;

    // Soft-interrupt instruction carrying an exception number in its low byte.
    function automatic logic [31:0] fault_word(input logic [7:0] num);
        return {OPC_SOFTINT, 19'd0, num};
    endfunction

endpackage

// File: rtl/order_bus_responder_if.sv
// Fetch-side and memory-side signals of the responder, bundled for port connection.
interface order_bus_responder_if;

    logic [31:0] add_bus;
    logic [31:0] data_bus;
    logic        isCplt;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  add_bus, flush, mem_ack, mem_rdata,
        output data_bus, isCplt, mem_req, mem_addr
    );

    modport master (
        output add_bus, flush, mem_ack, mem_rdata,
        input  data_bus, isCplt, mem_req, mem_addr
    );

endinterface

// File: rtl/order_buf_array.sv
// Direct-mapped line store: async read, one write port, flush clears all valid bits (flush beats write).
// Latency: read is combinational, write/flush take effect at the next edge. No backpressure.
module order_buf_array #(
    parameter int LINES = 16,
    parameter int IDX   = $clog2(LINES),
    parameter int TAGW  = 30 - IDX
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [IDX-1:0]  rd_idx,
    output logic            rd_vld,
    output logic [TAGW-1:0] rd_tag,
    output logic [31:0]     rd_word,
    input  logic            wr_en,
    input  logic [IDX-1:0]  wr_idx,
    input  logic [TAGW-1:0] wr_tag,
    input  logic [31:0]     wr_word
);

    logic [LINES-1:0] vld;
    logic [TAGW-1:0]  tag_mem  [LINES];
    logic [31:0]      word_mem [LINES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
        end else if (flush) begin
            vld <= '0;
        end else if (wr_en) begin
            vld[wr_idx] <= 1'b1;
        end
    end

    // Payload needs no reset: it is only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            word_mem[wr_idx] <= wr_word;
        end
    end

    assign rd_vld  = vld[rd_idx];
    assign rd_tag  = tag_mem[rd_idx];
    assign rd_word = word_mem[rd_idx];

endmodule

// File: rtl/order_bus_responder.sv
// Instruction-fetch responder: buffered hits in 0 cycles, misses filled over mem_req/mem_ack with timeout.
// Latency: hit 0, miss 1 + memory latency. Fetch is stalled by isCplt=0; one outstanding memory request.
module order_bus_responder
    import order_bus_responder_pkg::*;
#(
    parameter int         LINES     = 16,
    parameter int         TIMEOUT   = 255,
    parameter logic [7:0] FAULT_NUM = FAULT_NUM_DEF,
    parameter logic [7:0] ALIGN_NUM = ALIGN_NUM_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    order_bus_responder_if.slave   bus
);

    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = 30 - IDX;
    localparam int CW   = $clog2(TIMEOUT + 1);

    state_t          state;
    logic [CW-1:0]   count;
    logic            poison;
    logic            mem_req_q;
    logic [31:0]     mem_addr_q;

    logic            rd_vld;
    logic [TAGW-1:0] rd_tag;
    logic [31:0]     rd_word;

    logic            misaligned;
    logic            hit;
    logic            addr_match;
    logic            fill;
    logic            timeout;
    logic            wr_en;
    logic            cplt;
    logic [31:0]     data;

    assign misaligned = (bus.add_bus[1:0] != 2'b00);
    assign hit        = rd_vld && (rd_tag == bus.add_bus[31:IDX+2]);
    assign addr_match = (bus.add_bus == mem_addr_q);
    assign fill       = (state == WAIT) && bus.mem_ack;
    assign timeout    = (state == WAIT) && !bus.mem_ack && (count == CW'(TIMEOUT));
    assign wr_en      = fill && !poison;

    order_buf_array #(
        .LINES (LINES),
        .IDX   (IDX),
        .TAGW  (TAGW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.flush),
        .rd_idx  (bus.add_bus[IDX+1:2]),
        .rd_vld  (rd_vld),
        .rd_tag  (rd_tag),
        .rd_word (rd_word),
        .wr_en   (wr_en),
        .wr_idx  (mem_addr_q[IDX+1:2]),
        .wr_tag  (mem_addr_q[31:IDX+2]),
        .wr_word (bus.mem_rdata)
    );

    // Response mux; bypass and fault words only reach fetch if it still asks for the pending address.
    always_comb begin
        cplt = 1'b0;
        data = 32'd0;
        if (!rst) begin
            cplt = 1'b0;
        end else if (misaligned) begin
            cplt = 1'b1;
            data = fault_word(ALIGN_NUM);
        end else if ((state == IDLE) && hit) begin
            cplt = 1'b1;
            data = rd_word;
        end else if (fill && addr_match) begin
            cplt = 1'b1;
            data = bus.mem_rdata;
        end else if (timeout && addr_match) begin
            cplt = 1'b1;
            data = fault_word(FAULT_NUM);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'd0;
            count      <= '0;
            poison     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!misaligned && !hit) begin
                        mem_addr_q <= {bus.add_bus[31:2], 2'b00};
                        mem_req_q  <= 1'b1;
                        count      <= '0;
                        poison     <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_ack || timeout) begin
                        mem_req_q <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        count <= count + 1'b1;
                        // A flush while the fill is in flight means the returned word must not be kept.
                        if (bus.flush) begin
                            poison <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.isCplt   = cplt;
    assign bus.data_bus = data;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;

endmodule

// File: tb/tb_order_bus_responder.sv
// Randomized and directed checking of order_bus_responder against a behavioural fetch/memory model.
module tb_order_bus_responder;

    localparam int TO = 255;

    logic clk = 1'b0;
    logic rst = 1'b0;

    order_bus_responder_if bus_if();

    order_bus_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: outstanding request plus the address/word resident in each line.
    bit          m_req;
    logic [31:0] m_addr;
    int          m_age;
    bit          m_poison;
    bit          c_vld  [16];
    logic [31:0] c_addr [16];
    logic [31:0] c_dat  [16];

    logic        s_cplt;
    logic [31:0] s_data;
    logic        s_req;
    logic [31:0] s_addr;

    function automatic logic [31:0] softint(input logic [7:0] n);
        return {5'd13, 19'd0, n};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_req    = 1'b0;
        m_addr   = 32'd0;
        m_age    = 0;
        m_poison = 1'b0;
        for (int i = 0; i < 16; i++) c_vld[i] = 1'b0;
    endtask

    // One clock cycle: apply inputs, compare against the model mid-cycle, then advance the model.
    task automatic cyc(input logic [31:0] a, input bit fl, input bit ack, input logic [31:0] rd);
        int          ln;
        int          ml;
        bit          mis;
        bit          hit;
        logic        e_c;
        logic [31:0] e_d;
        bus_if.add_bus   = a;
        bus_if.flush     = fl;
        bus_if.mem_ack   = ack;
        bus_if.mem_rdata = rd;
        @(negedge clk);
        s_cplt = bus_if.isCplt;
        s_data = bus_if.data_bus;
        s_req  = bus_if.mem_req;
        s_addr = bus_if.mem_addr;
        ln  = int'((a >> 2) % 16);
        ml  = int'((m_addr >> 2) % 16);
        mis = (a % 4) != 0;
        hit = !mis && c_vld[ln] && (c_addr[ln] == a);
        e_c = 1'b0;
        e_d = 32'd0;
        if (rst) begin
            if (mis) begin
                e_c = 1'b1; e_d = softint(8'd18);
            end else if (!m_req && hit) begin
                e_c = 1'b1; e_d = c_dat[ln];
            end else if (m_req && ack && a == m_addr) begin
                e_c = 1'b1; e_d = rd;
            end else if (m_req && !ack && m_age == TO && a == m_addr) begin
                e_c = 1'b1; e_d = softint(8'd17);
            end
        end
        chk("model isCplt", s_cplt, e_c);
        chk("model data_bus", s_data, e_d);
        chk("model mem_req", s_req, m_req);
        chk("model mem_addr", s_addr, m_addr);
        if (rst) begin
            if (m_req) begin
                if (ack) begin
                    if (!m_poison) begin
                        c_vld[ml] = 1'b1; c_addr[ml] = m_addr; c_dat[ml] = rd;
                    end
                    m_req = 1'b0;
                end else if (m_age == TO) begin
                    m_req = 1'b0;
                end else begin
                    m_age++;
                    if (fl) m_poison = 1'b1;
                end
            end else if (!mis && !hit) begin
                m_req = 1'b1; m_addr = {a[31:2], 2'b00}; m_age = 0; m_poison = 1'b0;
            end
            if (fl) for (int i = 0; i < 16; i++) c_vld[i] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Full miss from IDLE: miss cycle, lat silent cycles, then ack with bypass.
    task automatic serve(input logic [31:0] a, input logic [31:0] d, input int lat, input string nm);
        cyc(a, 1'b0, 1'b0, 32'd0);
        chk({nm, " miss cplt"}, s_cplt, 32'd0);
        repeat (lat) cyc(a, 1'b0, 1'b0, 32'd0);
        cyc(a, 1'b0, 1'b1, d);
        chk({nm, " bypass cplt"}, s_cplt, 32'd1);
        chk({nm, " bypass data"}, s_data, d);
    endtask

    initial begin
        logic [31:0] a_cur;
        logic [31:0] pick;
        bit          fl;
        bit          ack;
        int          lat;
        bit          lat_valid;

        bus_if.add_bus   = 32'd0;
        bus_if.flush     = 1'b0;
        bus_if.mem_ack   = 1'b0;
        bus_if.mem_rdata = 32'd0;
        model_reset();

        @(negedge clk);
        chk("reset isCplt", bus_if.isCplt, 32'd0);
        chk("reset data_bus", bus_if.data_bus, 32'd0);
        chk("reset mem_req", bus_if.mem_req, 32'd0);
        chk("reset mem_addr", bus_if.mem_addr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Cold miss, ack three cycles after the request, then a 0-cycle hit.
        cyc(32'h0, 1'b0, 1'b0, 32'd0);
        chk("cold miss cplt", s_cplt, 32'd0);
        cyc(32'h0, 1'b0, 1'b0, 32'd0);
        chk("cold req raised", s_req, 32'd1);
        cyc(32'h0, 1'b0, 1'b0, 32'd0);
        cyc(32'h0, 1'b0, 1'b0, 32'd0);
        cyc(32'h0, 1'b0, 1'b1, 32'h5800_0100);
        chk("cold ack cplt", s_cplt, 32'd1);
        chk("cold ack data", s_data, 32'h5800_0100);
        cyc(32'h0, 1'b0, 1'b0, 32'd0);
        chk("cold hit cplt", s_cplt, 32'd1);
        chk("cold hit data", s_data, 32'h5800_0100);
        chk("cold hit no req", s_req, 32'd0);

        // Conflict eviction on line 0; line 1 untouched.
        serve(32'h40, 32'h1111_0040, 2, "conflict 0x40");
        serve(32'h4, 32'h2222_0004, 0, "fill 0x4");
        serve(32'h0, 32'h3333_0000, 1, "refetch 0x0");
        cyc(32'h4, 1'b0, 1'b0, 32'd0);
        chk("line1 kept data", s_data, 32'h2222_0004);
        serve(32'h40, 32'h1111_0040, 0, "refetch 0x40");

        // Misaligned fetch.
        cyc(32'h2, 1'b0, 1'b0, 32'd0);
        chk("misalign cplt", s_cplt, 32'd1);
        chk("misalign data", s_data, 32'h6800_0012);
        cyc(32'h2, 1'b0, 1'b0, 32'd0);
        chk("misalign no req", s_req, 32'd0);

        // Timeout, late ack ignored, refetch misses again.
        cyc(32'h100, 1'b0, 1'b0, 32'd0);
        repeat (TO) cyc(32'h100, 1'b0, 1'b0, 32'd0);
        cyc(32'h100, 1'b0, 1'b0, 32'd0);
        chk("timeout cplt", s_cplt, 32'd1);
        chk("timeout data", s_data, 32'h6800_0011);
        cyc(32'h100, 1'b0, 1'b1, 32'hDEAD_BEEF);
        chk("late ack req", s_req, 32'd0);
        chk("late ack cplt", s_cplt, 32'd0);
        cyc(32'h100, 1'b0, 1'b0, 32'd0);
        chk("refetch req", s_req, 32'd1);
        cyc(32'h100, 1'b0, 1'b1, 32'hCAFE_0100);
        chk("refetch data", s_data, 32'hCAFE_0100);

        // Flush during WAIT poisons the fill but still bypasses it.
        cyc(32'h80, 1'b0, 1'b0, 32'd0);
        cyc(32'h80, 1'b1, 1'b0, 32'd0);
        cyc(32'h80, 1'b0, 1'b0, 32'd0);
        cyc(32'h80, 1'b0, 1'b1, 32'h1234_5678);
        chk("poisoned bypass data", s_data, 32'h1234_5678);
        serve(32'h80, 32'h5555_0080, 1, "post-flush 0x80");
        serve(32'h4, 32'h6666_0004, 0, "post-flush 0x4");
        cyc(32'h80, 1'b0, 1'b0, 32'd0);
        chk("hit 0x80", s_data, 32'h5555_0080);
        cyc(32'h4, 1'b1, 1'b0, 32'd0);
        chk("hit during flush", s_cplt, 32'd1);
        serve(32'h80, 32'h7777_0080, 0, "idle-flush 0x80");
        serve(32'h4, 32'h8888_0004, 0, "idle-flush 0x4");

        // Asynchronous reset mid-WAIT.
        cyc(32'h8, 1'b0, 1'b0, 32'd0);
        cyc(32'h8, 1'b0, 1'b0, 32'd0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async rst req", bus_if.mem_req, 32'd0);
        chk("async rst cplt", bus_if.isCplt, 32'd0);
        cyc(32'h8, 1'b0, 1'b0, 32'd0);
        cyc(32'h8, 1'b0, 1'b0, 32'd0);
        rst = 1'b1;
        serve(32'h4, 32'h9999_0004, 1, "post-reset 0x4");

        // Random traffic against the model.
        a_cur     = 32'h0;
        lat       = 0;
        lat_valid = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (s_cplt || $urandom_range(0, 7) == 0) begin
                pick  = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2);
                pick  = pick | ($urandom_range(0, 1) << 20);
                if ($urandom_range(0, 15) == 0) pick = pick | $urandom_range(1, 3);
                a_cur = pick;
            end
            fl = ($urandom_range(0, 24) == 0);
            if (!m_req) lat_valid = 1'b0;
            if (m_req && !lat_valid) begin
                lat       = ($urandom_range(0, 39) == 0) ? 400 : $urandom_range(0, 5);
                lat_valid = 1'b1;
            end
            ack = m_req ? (m_age == lat) : ($urandom_range(0, 9) == 0);
            cyc(a_cur, fl, ack, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
